wb_cmd_master: RTL

Wishbone classic (B3, non-pipelined) initiator that turns a single-beat command from a host-side front end (e.g. SPI deframer) into a bus read or write. It drives the master port of the system Wishbone mux, which routes to the LED and counter slaves. It returns read data plus a completion status on a valid/ready response channel. It handles slave ERR, RTY (bounded retry) and an optional watchdog timeout.

---
 rtl/wbm_pkg.sv | 13 +
 rtl/wb_cmd_master_if.sv | 43 ++++
 rtl/wbm_timeout_ctr.sv | 26 ++
 rtl/wb_cmd_master.sv | 134 +++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// Shared definitions for the Wishbone command master.
// This file holds the completion status codes, the FSM state type and the default bus widths.
package wbm_pkg;
  localparam int WBM_DW = 32;
  localparam int WBM_AW = 32;

  localparam logic [1:0] WBM_ST_OK  = 2'd0;
  localparam logic [1:0] WBM_ST_ERR = 2'd1;
  localparam logic [1:0] WBM_ST_RTY = 2'd2;
  localparam logic [1:0] WBM_ST_TMO = 2'd3;

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} wbm_state_e;
endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response channel plus Wishbone master signals for wb_cmd_master.
// The master modport is the initiator side. The slave modport is the front end and bus side.
interface wb_cmd_master_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_adr;
  logic [DATA_WIDTH-1:0]   cmd_dat;
  logic [SELECT_WIDTH-1:0] cmd_sel;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_dat;
  logic [1:0]              rsp_status;
  logic                    busy;
  logic [ADDR_WIDTH-1:0]   wbm_adr_o;
  logic [DATA_WIDTH-1:0]   wbm_dat_o;
  logic [DATA_WIDTH-1:0]   wbm_dat_i;
  logic                    wbm_we_o;
  logic [SELECT_WIDTH-1:0] wbm_sel_o;
  logic                    wbm_stb_o;
  logic                    wbm_cyc_o;
  logic                    wbm_ack_i;
  logic                    wbm_err_i;
  logic                    wbm_rty_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_status, busy,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_status, busy,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );
endinterface

// File: rtl/wbm_timeout_ctr.sv
// BUS-phase watchdog counter.
// The counter is held at zero while i_clr is high and counts cycles while i_en is high.
// o_expired is high in the cycle where the count would reach LIMIT.
module wbm_timeout_ctr #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam logic [W-1:0] LAST = W'(LIMIT-1);

  logic [W-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == LAST);

  // Count unterminated BUS cycles, saturating at the last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_en && r_cnt != LAST)  r_cnt <= r_cnt + W'(1);
  end
endmodule

// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone B3 classic initiator with bounded RTY retry.
// Optional watchdog: define WBM_TIMEOUT_EN to abort a BUS phase after TIMEOUT_CYCLES.
// All outputs are driven from flops. stb always equals cyc (no pipelining).
module wb_cmd_master
  import wbm_pkg::*;
#(
  parameter int DATA_WIDTH     = WBM_DW,
  parameter int ADDR_WIDTH     = WBM_AW,
  parameter int SELECT_WIDTH   = DATA_WIDTH/8,
  parameter int RETRY_MAX      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  wb_cmd_master_if.master wb
);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX+1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  wbm_state_e              r_state;
  logic [RW-1:0]           r_retry;
  logic                    r_cyc;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [SELECT_WIDTH-1:0] r_sel;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_dat;
  logic [1:0]              r_rsp_status;
  logic                    r_busy;
  logic                    r_cmd_ready;
  logic                    w_tmo;

`ifdef WBM_TIMEOUT_EN
  logic w_term;
  assign w_term = wb.wbm_ack_i | wb.wbm_err_i | wb.wbm_rty_i;

  // Leaving BUS, including for BACKOFF, restarts the watchdog.
  wbm_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state != BUS),
    .i_en      ((r_state == BUS) && !w_term),
    .o_expired (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  assign wb.cmd_ready  = r_cmd_ready;
  assign wb.busy       = r_busy;
  assign wb.rsp_valid  = r_rsp_valid;
  assign wb.rsp_dat    = r_rsp_dat;
  assign wb.rsp_status = r_rsp_status;
  assign wb.wbm_adr_o  = r_adr;
  assign wb.wbm_dat_o  = r_dat;
  assign wb.wbm_we_o   = r_we;
  assign wb.wbm_sel_o  = r_sel;
  assign wb.wbm_cyc_o  = r_cyc;
  assign wb.wbm_stb_o  = r_cyc;

  // Main FSM. Outputs are set together with the next state so that they are valid from the cycle after each decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_retry      <= '0;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= WBM_ST_OK;
      r_busy       <= 1'b0;
      r_cmd_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (wb.cmd_valid && r_cmd_ready) begin
            r_adr       <= wb.cmd_adr;
            r_dat       <= wb.cmd_dat;
            r_sel       <= wb.cmd_sel;
            r_we        <= wb.cmd_we;
            r_retry     <= '0;
            r_cyc       <= 1'b1;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= BUS;
          end
        end
        BUS: begin
          // Termination priority is err > ack > rty. A timeout happens only when no termination is present.
          if (wb.wbm_err_i || wb.wbm_ack_i || w_tmo ||
              (wb.wbm_rty_i && r_retry == RETRY_LIM)) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
            if (wb.wbm_err_i) begin
              r_rsp_status <= WBM_ST_ERR;
              r_rsp_dat    <= '0;
            end else if (wb.wbm_ack_i) begin
              r_rsp_status <= WBM_ST_OK;
              r_rsp_dat    <= r_we ? '0 : wb.wbm_dat_i;
            end else if (wb.wbm_rty_i) begin
              r_rsp_status <= WBM_ST_RTY;
              r_rsp_dat    <= '0;
            end else begin
              r_rsp_status <= WBM_ST_TMO;
              r_rsp_dat    <= '0;
            end
          end else if (wb.wbm_rty_i) begin
            r_retry <= r_retry + RW'(1);
            r_cyc   <= 1'b0;
            r_state <= BACKOFF;
          end
        end
        BACKOFF: begin
          r_cyc   <= 1'b1;
          r_state <= BUS;
        end
        RESP: begin
          if (wb.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
